// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Resolves conditional branches in EX against the guess made at fetch by the
//   branch history table (BHT), and drives the writer side of the BHT update
//   interface. Each fetch's guess (BHT state and predicted next PC) rides
//   through IF/ID/EX shadow slots in lock-step with the core pipeline. At EX a
//   misprediction produces a registered PC redirect and flush, the wrong-path
//   shadow entries are killed, and a one-cycle RECOVER state discards the
//   fetch that was already in flight.
//
// Parameters:
//   ADDR_W  width of word-address PC values (instruction memory address width,
//           default 12)
//   CNT_W   width of the performance counters (only with BRU_PERF_CNT_EN)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   pipe_en            core pipeline advance (0 = stall, shadow slots hold)
//   if_valid, if_pc_4, if_guess_pc, if_guess_state
//                      fetch slot contents and the BHT guess returned with it
//   ex_is_branch, ex_taken, ex_target
//                      branch information computed in EX
//   update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ
//                      registered one-cycle BHT update strobe and payload
//   redirect_en, redirect_pc
//                      registered one-cycle PC redirect to fetch
//   flush              kill IF and ID in the core (same cycle as redirect_en)
//   busy               RECOVER state indicator
//   perf_branches, perf_mispredicts
//                      saturating event counters (only with BRU_PERF_CNT_EN)
//
// Configuration macro:
//   BRU_PERF_CNT_EN    when defined, adds the two performance counter outputs
// -----------------------------------------------------------------------------

module branch_resolve_unit #(
  parameter int ADDR_W = 12
`ifdef BRU_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc_4,
  input  logic [ADDR_W-1:0] if_guess_pc,
  input  logic [1:0]        if_guess_state,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              update_en,
  output logic [ADDR_W-1:0] update_pc_4,
  output logic [ADDR_W-1:0] update_pc_remote,
  output logic [1:0]        update_state_old,
  output logic              branch_succ,
  output logic              redirect_en,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_mispredicts
`endif
);

  typedef enum logic {
    RUN,
    RECOVER
  } state_t;

  state_t state;
  state_t state_next;

  // Shadow slot for the instruction currently in ID
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc_4;
  logic [ADDR_W-1:0] id_guess_pc;
  logic [1:0]        id_guess_state;

  // Shadow slot for the instruction currently in EX
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc_4;
  logic [ADDR_W-1:0] ex_guess_pc;
  logic [1:0]        ex_guess_state;

  logic              resolve;
  logic              mispredict;
  logic [ADDR_W-1:0] actual_pc;
  logic              fetch_accept;

  // Resolution only happens when the EX instruction actually leaves EX. A
  // non-branch also resolves: if its guess differs from pc_4 the BHT aliased
  // it onto a branch entry and fetch went the wrong way.
  always_comb begin
    resolve    = ex_valid & pipe_en & (state == RUN);
    actual_pc  = (ex_is_branch & ex_taken) ? ex_target : ex_pc_4;
    mispredict = resolve & (actual_pc != ex_guess_pc);
  end

  // While recovering, the instruction sitting in the fetch slot was fetched
  // before the redirect took effect, so it must not enter the shadow pipe.
  assign fetch_accept = if_valid & (state == RUN);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: RECOVER lasts until one pipe_en=1 cycle has been consumed
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        if (pipe_en) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign busy = (state == RECOVER);

  // Shadow pipe advances with the core; a mispredict kills both slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid       <= 1'b0;
      id_pc_4        <= '0;
      id_guess_pc    <= '0;
      id_guess_state <= 2'b00;
      ex_valid       <= 1'b0;
      ex_pc_4        <= '0;
      ex_guess_pc    <= '0;
      ex_guess_state <= 2'b00;
    end else if (pipe_en) begin
      id_valid       <= fetch_accept & ~mispredict;
      id_pc_4        <= if_pc_4;
      id_guess_pc    <= if_guess_pc;
      id_guess_state <= if_guess_state;
      ex_valid       <= id_valid & ~mispredict;
      ex_pc_4        <= id_pc_4;
      ex_guess_pc    <= id_guess_pc;
      ex_guess_state <= id_guess_state;
    end
  end

  // Registered strobes and payloads; strobes are single-cycle pulses and the
  // payload registers capture only on a resolution so they stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_en        <= 1'b0;
      update_pc_4      <= '0;
      update_pc_remote <= '0;
      update_state_old <= 2'b00;
      branch_succ      <= 1'b0;
      redirect_en      <= 1'b0;
      redirect_pc      <= '0;
      flush            <= 1'b0;
    end else begin
      update_en   <= resolve & ex_is_branch;
      redirect_en <= mispredict;
      flush       <= mispredict;
      if (resolve) begin
        update_pc_4      <= ex_pc_4;
        update_pc_remote <= ex_target;
        update_state_old <= ex_guess_state;
        branch_succ      <= ex_taken;
        redirect_pc      <= actual_pc;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Event counters follow the registered strobes and stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (update_en && (perf_branches != {CNT_W{1'b1}})) begin
        perf_branches <= perf_branches + 1'b1;
      end
      if (redirect_en && (perf_mispredicts != {CNT_W{1'b1}})) begin
        perf_mispredicts <= perf_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Purpose:
//   Self-checking bench for branch_resolve_unit: directed scenarios for the
//   prediction outcomes, BHT alias, stalls, recovery and reset, followed by a
//   randomized run checked against an instruction-level reference model.
//   Performance counter checks are included when BRU_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------

module tb_branch_resolve_unit;

  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic          pipe_en;
  logic          if_valid;
  logic [AW-1:0] if_pc_4;
  logic [AW-1:0] if_guess_pc;
  logic [1:0]    if_guess_state;
  logic          ex_is_branch;
  logic          ex_taken;
  logic [AW-1:0] ex_target;
  logic          update_en;
  logic [AW-1:0] update_pc_4;
  logic [AW-1:0] update_pc_remote;
  logic [1:0]    update_state_old;
  logic          branch_succ;
  logic          redirect_en;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic          busy;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]   perf_branches;
  logic [31:0]   perf_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(
    .ADDR_W(AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_en          (pipe_en),
    .if_valid         (if_valid),
    .if_pc_4          (if_pc_4),
    .if_guess_pc      (if_guess_pc),
    .if_guess_state   (if_guess_state),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .update_en        (update_en),
    .update_pc_4      (update_pc_4),
    .update_pc_remote (update_pc_remote),
    .update_state_old (update_state_old),
    .branch_succ      (branch_succ),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .busy             (busy)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wall-clock guard so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic v, input logic [AW-1:0] p, input logic [AW-1:0] g,
                          input logic [1:0] s);
    if_valid       = v;
    if_pc_4        = p;
    if_guess_pc    = g;
    if_guess_state = s;
  endtask

  task automatic drive_ex(input logic br, input logic tk, input logic [AW-1:0] tgt);
    ex_is_branch = br;
    ex_taken     = tk;
    ex_target    = tgt;
  endtask

  // Idle one cycle, then walk one instruction from IF into the EX shadow slot
  task automatic load_ex(input logic [AW-1:0] p, input logic [AW-1:0] g, input logic [1:0] s);
    pipe_en = 1'b1;
    drive_ex(1'b0, 1'b0, '0);
    drive_if(1'b0, '0, '0, 2'b00);
    cycle();
    drive_if(1'b1, p, g, s);
    cycle();
    drive_if(1'b0, '0, '0, 2'b00);
    cycle();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    pipe_en = 1'b0;
    drive_if(1'b0, '0, '0, 2'b00);
    drive_ex(1'b0, 1'b0, '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    logic [AW*3+7:0] obs;
    $display("[TB] test_reset");
    do_reset();
    obs = {update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
           redirect_en, redirect_pc, flush, busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
`ifdef BRU_PERF_CNT_EN
    n_checks++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", perf_branches, perf_mispredicts);
    end
`endif
  endtask

  task automatic test_nt_correct();
    $display("[TB] test_nt_correct");
    load_ex(12'h010, 12'h010, 2'b01);
    drive_ex(1'b1, 1'b0, 12'h055);
    cycle();
    n_checks++;
    if ({update_en, update_pc_4, update_state_old, branch_succ, redirect_en, flush, busy}
        !== {1'b1, 12'h010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL nt_correct: upd=%b pc=%h st=%b succ=%b red=%b fl=%b busy=%b expected 1 010 01 0 0 0 0",
               update_en, update_pc_4, update_state_old, branch_succ, redirect_en, flush, busy);
    end
  endtask

  task automatic test_t_pred_nt_actual();
    $display("[TB] test_t_pred_nt_actual");
    load_ex(12'h011, 12'h040, 2'b11);
    drive_ex(1'b1, 1'b0, 12'h040);
    cycle();
    n_checks++;
    if ({redirect_en, redirect_pc, flush, update_en, update_state_old, branch_succ, busy}
        !== {1'b1, 12'h011, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL taken_mispredict: red=%b rpc=%h fl=%b upd=%b st=%b succ=%b busy=%b expected 1 011 1 1 11 0 1",
               redirect_en, redirect_pc, flush, update_en, update_state_old, branch_succ, busy);
    end
    // Wrong-path fetch during RECOVER must vanish
    drive_ex(1'b0, 1'b0, '0);
    drive_if(1'b1, 12'h200, 12'h200, 2'b00);
    cycle();
    n_checks++;
    if ({busy, redirect_en, flush, update_en} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL recover_one_cycle: busy=%b red=%b fl=%b upd=%b expected 0 0 0 0",
               busy, redirect_en, flush, update_en);
    end
    drive_if(1'b0, '0, '0, 2'b00);
    cycle();
    drive_ex(1'b1, 1'b1, 12'h333);
    cycle();
    n_checks++;
    if ({update_en, redirect_en} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL recover_discard: upd=%b red=%b expected 0 0", update_en, redirect_en);
    end
  endtask

  task automatic test_nt_pred_t_actual();
    $display("[TB] test_nt_pred_t_actual");
    load_ex(12'h021, 12'h021, 2'b01);
    drive_ex(1'b1, 1'b1, 12'h080);
    cycle();
    n_checks++;
    if ({redirect_en, redirect_pc, update_en, update_pc_4, update_pc_remote, branch_succ}
        !== {1'b1, 12'h080, 1'b1, 12'h021, 12'h080, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL nt_mispredict: red=%b rpc=%h upd=%b upc=%h rem=%h succ=%b expected 1 080 1 021 080 1",
               redirect_en, redirect_pc, update_en, update_pc_4, update_pc_remote, branch_succ);
    end
  endtask

  task automatic test_alias();
    $display("[TB] test_alias");
    load_ex(12'h031, 12'h100, 2'b10);
    drive_ex(1'b0, 1'b0, 12'h0AB);
    cycle();
    n_checks++;
    if ({redirect_en, redirect_pc, flush, update_en} !== {1'b1, 12'h031, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL alias: red=%b rpc=%h fl=%b upd=%b expected 1 031 1 0",
               redirect_en, redirect_pc, flush, update_en);
    end
  endtask

  task automatic test_stall();
    $display("[TB] test_stall");
    load_ex(12'h050, 12'h040, 2'b11);
    drive_ex(1'b1, 1'b0, 12'h040);
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({update_en, redirect_en, flush} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL stall_quiet[%0d]: upd=%b red=%b fl=%b expected 0 0 0",
                 i, update_en, redirect_en, flush);
      end
    end
    pipe_en = 1'b1;
    cycle();
    n_checks++;
    if ({update_en, redirect_en, redirect_pc} !== {1'b1, 1'b1, 12'h050}) begin
      n_fail++;
      $display("[TB] FAIL stall_release: upd=%b red=%b rpc=%h expected 1 1 050",
               update_en, redirect_en, redirect_pc);
    end
    cycle();
    n_checks++;
    if ({update_en, redirect_en, busy} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL stall_single_pulse: upd=%b red=%b busy=%b expected 0 0 0",
               update_en, redirect_en, busy);
    end
  endtask

  task automatic test_recover_stall();
    $display("[TB] test_recover_stall");
    load_ex(12'h060, 12'h061, 2'b00);
    drive_ex(1'b0, 1'b0, '0);
    cycle();
    pipe_en = 1'b0;
    drive_if(1'b1, 12'h300, 12'h300, 2'b01);
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({busy, redirect_en} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL recover_hold[%0d]: busy=%b red=%b expected 1 0", i, busy, redirect_en);
      end
    end
    pipe_en = 1'b1;
    cycle();
    drive_if(1'b0, '0, '0, 2'b00);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL recover_exit: busy=%b expected 0", busy);
    end
    cycle();
    drive_ex(1'b1, 1'b1, 12'h3AA);
    cycle();
    n_checks++;
    if ({update_en, redirect_en} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL recover_stall_discard: upd=%b red=%b expected 0 0", update_en, redirect_en);
    end
  endtask

  task automatic test_reset_mid_recovery();
    logic [AW*3+7:0] obs;
    $display("[TB] test_reset_mid_recovery");
    load_ex(12'h070, 12'h071, 2'b10);
    drive_ex(1'b1, 1'b0, '0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
           redirect_en, redirect_pc, flush, busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got %h expected 0", obs);
    end
    cycle();
    rst_n = 1'b1;
    drive_ex(1'b1, 1'b1, 12'hFFF);
    cycle();
    cycle();
    n_checks++;
    if ({update_en, redirect_en, flush, busy} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_no_pulse: upd=%b red=%b fl=%b busy=%b expected 0 0 0 0",
               update_en, redirect_en, flush, busy);
    end
    drive_ex(1'b0, 1'b0, '0);
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf();
    $display("[TB] test_perf");
    do_reset();
    n_checks++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL perf_after_reset: got %0d/%0d expected 0/0", perf_branches, perf_mispredicts);
    end
    load_ex(12'h010, 12'h010, 2'b01);
    drive_ex(1'b1, 1'b0, 12'h055);
    cycle();
    load_ex(12'h011, 12'h040, 2'b11);
    drive_ex(1'b1, 1'b0, 12'h040);
    cycle();
    load_ex(12'h021, 12'h021, 2'b01);
    drive_ex(1'b1, 1'b0, 12'h099);
    cycle();
    drive_ex(1'b0, 1'b0, '0);
    cycle();
    cycle();
    n_checks++;
    if (perf_branches !== 32'd3 || perf_mispredicts !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL perf_counts: got %0d/%0d expected 3/1", perf_branches, perf_mispredicts);
    end
  endtask
`endif

  // Reference model: the in-flight instructions are a two-entry queue,
  // element 0 in ID and element 1 in EX; a fetch pushes at the front and
  // the oldest drops off the back when the pipeline advances.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] pc_4;
    logic [AW-1:0] guess_pc;
    logic [1:0]    st;
  } ins_t;

  task automatic test_random();
    ins_t          flight[$];
    ins_t          older;
    ins_t          fetched;
    logic          recovering;
    logic          exp_upd, exp_red, wrong;
    logic [AW-1:0] exp_upc, exp_rem, exp_rpc, actual;
    logic [1:0]    exp_st;
    logic          exp_succ;
    $display("[TB] test_random");
    do_reset();
    flight.delete();
    flight.push_back('0);
    flight.push_back('0);
    recovering = 1'b0;
    for (int n = 0; n < 800; n++) begin
      older   = flight[1];
      pipe_en = ($urandom_range(0, 4) != 0);
      fetched.valid    = ($urandom_range(0, 3) != 0);
      fetched.pc_4     = ($urandom_range(0, 15) == 0) ? 12'hFFF : AW'($urandom_range(0, 4095));
      fetched.guess_pc = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 4095)) : fetched.pc_4;
      fetched.st       = 2'($urandom_range(0, 3));
      drive_if(fetched.valid, fetched.pc_4, fetched.guess_pc, fetched.st);
      drive_ex(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 0) ? older.guess_pc : AW'($urandom_range(0, 4095)));

      exp_upd = 1'b0;
      exp_red = 1'b0;
      exp_upc = '0;
      exp_rem = '0;
      exp_st  = 2'b00;
      exp_succ = 1'b0;
      exp_rpc = '0;
      wrong   = 1'b0;
      if (pipe_en) begin
        if (older.valid) begin
          actual   = (ex_is_branch && ex_taken) ? ex_target : older.pc_4;
          wrong    = (actual != older.guess_pc);
          exp_upd  = ex_is_branch;
          exp_upc  = older.pc_4;
          exp_rem  = ex_target;
          exp_st   = older.st;
          exp_succ = ex_taken;
          exp_red  = wrong;
          exp_rpc  = actual;
        end
        if (recovering) begin
          fetched.valid = 1'b0;
        end
        if (wrong) begin
          flight.delete();
          flight.push_back('0);
          flight.push_back('0);
        end else begin
          flight.push_front(fetched);
          void'(flight.pop_back());
        end
        recovering = wrong;
      end

      cycle();
      n_checks++;
      if ({update_en, redirect_en, flush, busy} !== {exp_upd, exp_red, exp_red, recovering}) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl[%0d]: upd/red/fl/busy=%b%b%b%b expected %b%b%b%b", n,
                 update_en, redirect_en, flush, busy, exp_upd, exp_red, exp_red, recovering);
      end
      if (exp_upd) begin
        n_checks++;
        if ({update_pc_4, update_pc_remote, update_state_old, branch_succ}
            !== {exp_upc, exp_rem, exp_st, exp_succ}) begin
          n_fail++;
          $display("[TB] FAIL rand_update[%0d]: pc=%h rem=%h st=%b succ=%b expected %h %h %b %b", n,
                   update_pc_4, update_pc_remote, update_state_old, branch_succ,
                   exp_upc, exp_rem, exp_st, exp_succ);
        end
      end
      if (exp_red) begin
        n_checks++;
        if (redirect_pc !== exp_rpc) begin
          n_fail++;
          $display("[TB] FAIL rand_redirect[%0d]: rpc=%h expected %h", n, redirect_pc, exp_rpc);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pipe_en = 1'b0;
    drive_if(1'b0, '0, '0, 2'b00);
    drive_ex(1'b0, 1'b0, '0);
    test_reset();
    test_nt_correct();
    test_t_pred_nt_actual();
    test_nt_pred_t_actual();
    test_alias();
    test_stall();
    test_recover_stall();
    test_reset_mid_recovery();
`ifdef BRU_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
